// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC generation and IF/ID capture stage.
// Sits directly in front of a combinational, word-indexed instruction memory.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   stall_in          - hold PC, IF/ID and fetch count
//   redirect_in       - load PC from redirect_pc_in (word-aligned)
//   redirect_pc_in    - byte-address redirect target
//   halt_in           - stop fetching until reset
//   imem_addr_out     - word index {2'b00, pc[31:2]} (combinational from PC)
//   imem_data_in      - instruction word for imem_addr_out
//   pc_out            - current PC (byte address)
//   ifid_instr_out    - captured instruction (0 when invalid)
//   ifid_pc4_out      - PC+4 of captured instruction
//   ifid_valid_out    - IF/ID holds a real instruction
//   fetch_count_out   - valid instructions captured since reset
//   fault_out         - sticky misaligned-redirect / out-of-range flag
//   halted_out        - high while halted
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        halt_in,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_data_in,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instr_out,
  output logic [31:0] ifid_pc4_out,
  output logic        ifid_valid_out,
  output logic [31:0] fetch_count_out,
  output logic        fault_out,
  output logic        halted_out
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned WIDX = XLEN - 2;
  localparam logic [WIDX-1:0] DEPTH_W = WIDX'(IMEM_DEPTH);

  typedef enum logic [0:0] {RUN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc_plus4;
  logic            out_of_range;

  assign pc_plus4     = pc_q + XLEN'(4);
  assign out_of_range = (pc_q[XLEN-1:2] >= DEPTH_W);

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  // Next-state: halt > redirect > stall > normal; HALTED freezes everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      RUN: begin
        if (halt_in) begin
          state_d = HALTED;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (redirect_in) begin
          pc_d    = {redirect_pc_in[XLEN-1:2], 2'b00};
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (redirect_pc_in[1:0] != 2'b00) fault_d = 1'b1;
        end else if (!stall_in) begin
          pc_d = pc_plus4;
          if (out_of_range) begin
            // Keep fetching past the end of memory, but never present garbage.
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
            fault_d = 1'b1;
          end else begin
            instr_d = imem_data_in;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + XLEN'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign imem_addr_out   = {2'b00, pc_q[XLEN-1:2]};
  assign pc_out          = pc_q;
  assign ifid_instr_out  = instr_q;
  assign ifid_pc4_out    = pc4_q;
  assign ifid_valid_out  = valid_q;
  assign fetch_count_out = count_q;
  assign fault_out       = fault_q;
  assign halted_out      = (state_q == HALTED);

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- PC-generation and IF/ID capture stage directly upstream of the combinational word-indexed instruction memory.
- Drives the memory word index, receives the instruction word in the same cycle, and registers the instruction plus PC+4 into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect, halt and out-of-range fetch detection.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_DEPTH, 256, number of 32-bit words in the instruction memory; word indices >= IMEM_DEPTH are out of range.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- stall_in  input  1  hold PC and IF/ID contents.
- redirect_in  input  1  load PC from redirect_pc_in (taken branch, j, jal, jr).
- redirect_pc_in  input  32  byte-address redirect target.
- halt_in  input  1  stop fetching until reset.
- imem_addr_out  output  32  word index to instruction memory, {2'b00, pc[31:2]}, combinational from PC.
- imem_data_in  input  32  instruction word returned combinationally for imem_addr_out.
- pc_out  output  32  current PC (byte address).
- ifid_instr_out  output  32  registered instruction; 32'h0000_0000 (NOP) when invalid.
- ifid_pc4_out  output  32  registered PC+4 of the captured instruction.
- ifid_valid_out  output  1  IF/ID holds a real instruction.
- fetch_count_out  output  32  number of valid instructions captured since reset.
- fault_out  output  1  sticky: misaligned redirect or out-of-range fetch occurred.
- halted_out  output  1  high in HALTED state.

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, ifid_instr_out=0, ifid_pc4_out=0, ifid_valid_out=0, fetch_count_out=0, fault_out=0, state=RUN, halted_out=0. Reset overrides every other input, including mid-stall and HALTED.
- States: RUN, HALTED. Transitions:
  - RUN->HALTED on halt_in=1.
  - HALTED->RUN only via rst.
- Priority per RUN cycle: halt_in > redirect_in > stall_in > normal.
- Normal (RUN, no stall/redirect/halt):
  - pc <= pc+4.
  - IF/ID <= {imem_data_in, pc+4, valid=1}.
  - fetch_count_out += 1.
  - Latency: the instruction at PC appears on ifid_instr_out one cycle after PC is presented.
- Stall: pc, IF/ID and fetch_count_out hold unchanged; imem_addr_out stays stable.
- Redirect (overrides stall):
  - pc <= {redirect_pc_in[31:2], 2'b00}.
  - IF/ID flushed to {0, 0, valid=0}; count unchanged.
  - If redirect_pc_in[1:0] != 0, set fault_out.
- Halt (overrides redirect):
  - pc holds; IF/ID flushed to NOP/invalid; enter HALTED.
  - In HALTED, stall/redirect/halt are ignored; pc, IF/ID and count are frozen.
- Out-of-range: if pc[31:2] >= IMEM_DEPTH in a normal cycle:
  - IF/ID captures NOP with valid=0.
  - pc still advances by 4.
  - fault_out set; count unchanged.
- Arithmetic: pc+4 is 32-bit modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). fetch_count_out wraps modulo 2^32.
- fault_out is sticky until rst; faults never stop fetching.
- pc[1:0] is always 2'b00.

Test Plan:
- Reset then 3 normal cycles with imem returning 32'h2008_0005, 32'h2009_0003, 32'h0109_5020 at word indices 0, 1, 2:
  - imem_addr_out = 0, 1, 2.
  - ifid_instr_out lags one cycle; ifid_pc4_out = 4, 8, 12.
  - fetch_count_out = 3; pc_out = 12.
- Stall 2 cycles at pc=8: pc_out, ifid_* and count unchanged for both cycles; after release, the next capture uses word 2 with ifid_pc4_out=12.
- Redirect to 32'h0000_0040 while stall_in=1: pc_out=32'h40 next cycle, ifid_valid_out=0, ifid_instr_out=0, count unchanged. The following cycle captures word 16 with ifid_pc4_out=32'h44.
- Redirect to 32'h0000_0042: pc_out=32'h40, fault_out=1, and fault_out stays 1 through the next 10 normal cycles.
- Redirect to 32'h0000_03FC (word 255) then 1 normal cycle: captures word 255 valid; next cycle pc=32'h400 -> out-of-range capture is NOP, valid=0, fault_out=1, pc_out=32'h404.
- halt_in=1 together with redirect_in=1: halted_out=1, pc_out unchanged, IF/ID invalid, count frozen for 5 cycles. rst=1 -> pc_out=RESET_PC, fault_out=0, halted_out=0, normal fetching resumes.
